// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that times the fixed memory latency; flags zero.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic [LAT_CNT_W-1:0] cnt,
  output logic                 zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-over-fetch priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_EFF - 1);

  arb_state_t           state;
  arb_owner_t           owner;
  logic                 win_d;
  logic                 grant;
  logic                 done;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_gnt;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win_d = d_req && (!i_req || (last_gnt == OWN_I));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= OWN_D;
    end else if (grant) begin
      last_gnt <= win_d ? OWN_D : OWN_I;
    end
  end
`else
  always_comb begin
    win_d = d_req;
  end
`endif

  // Grant strobes are gated by rst so every output drops the moment reset asserts.
  assign grant   = (state == IDLE) && (i_req || d_req) && rst;
  assign i_gnt   = grant && !win_d;
  assign d_gnt   = grant && win_d;
  assign m_en    = grant;
  assign m_we    = d_gnt && d_we;
  assign m_addr  = !grant ? '0 : (win_d ? d_addr : i_addr);
  assign m_wdata = m_we ? d_wdata : '0;

  assign busy     = (state == WAIT);
  assign done     = busy && cnt_zero;
  assign i_rvalid = done && (owner == OWN_I);
  assign d_rvalid = done && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_D;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= WAIT;
            owner <= win_d ? OWN_D : OWN_I;
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (LAT_LOAD),
    .dec      (busy),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port memory between the instruction-fetch requester and the load/store (LW/SW) requester of the datapath. It grants one requester at a time, drives the memory port, counts out the fixed memory latency and returns read data or a write acknowledge to the owning requester. It sits between the datapath and the memory, and it is what lets the core run against one unified memory instead of separate instruction and data memories.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from the m_en cycle until m_rdata is valid; legal range 1..4

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  one-cycle grant pulse to fetch
- i_rvalid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  DW  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_rvalid  out  1  load data valid, or store acknowledge
- d_rdata  out  DW  load data
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- busy  out  1  high in WAIT

## Operation
- FSM states: IDLE, WAIT.
- IDLE with no request: stay in IDLE. All strobes stay low.
- IDLE with any request:
  - Pick a winner combinationally.
  - In the same cycle, assert that requester's gnt and m_en, drive m_addr/m_we/m_wdata from the winner, and go to WAIT.
  - Fetch grants drive m_we = 0.
- Latch the owner and load the latency counter with MEM_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, pulse the owner's rvalid and set its rdata = m_rdata as a pass-through. Return to IDLE in that same cycle.
  - Store transactions pulse d_rvalid as an acknowledge. d_rdata is don't-care for stores.
- Requests that arrive during WAIT are not granted. Both gnt outputs stay low.
- The arbiter never latches a request. If a req drops before its gnt, no transaction occurs. A req still high after gnt is treated as a new request at the next IDLE.
- Reset values: state IDLE; counter 0; owner D; last_gnt D; every output 0, including m_addr, m_wdata, i_rdata and d_rdata.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, no rvalid is issued and the transaction is lost. Requesters reissue after reset.
- Unused rdata output: hold it at 0 when its rvalid is low.

## Timing
- A request seen in IDLE at cycle t gives gnt and m_en at cycle t.
- rvalid arrives at t+MEM_LAT.
- The next grant comes at the earliest at t+MEM_LAT+1.
- Peak throughput is one transaction per MEM_LAT+1 cycles.
- No combinational path from m_rdata to any control output. rdata outputs only are combinational from m_rdata.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requesters are high in IDLE, grant the one not in last_gnt.
  - last_gnt updates on every grant.
  - Because last_gnt resets to D, the first tie goes to fetch.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, data over fetch.
  - last_gnt is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - the state enum {IDLE, WAIT}
  - the owner enum {OWN_I, OWN_D}
  - the MEM_LAT range constants
- One sub-module, mem_arb_lat_cnt: a loadable down-counter with a zero flag, sized $clog2(4).
- Arbitration logic and the FSM stay in the top module.

## Test plan
- MEM_LAT=2, i_req alone at 0x0000_0040:
  - i_gnt and m_en at t, with m_addr=0x40 and m_we=0.
  - i_rvalid at t+2 with i_rdata equal to the memory word.
- Both requesters high at t, without the macro: d_gnt at t and i_gnt at t+3. i_gnt stays low through t+2.
- Both requesters high and held, with ARB_ROUND_ROBIN_EN: grants alternate i, d, i, d at t, t+3, t+6, t+9.
- Store d_we=1, addr 0x100, wdata 0xDEAD_BEEF:
  - m_we=1 and m_wdata=0xDEADBEEF for one cycle.
  - d_rvalid at t+MEM_LAT.
  - A following load from 0x100 returns 0xDEADBEEF.
- rst driven low one cycle after a grant:
  - All outputs go to 0 asynchronously and no rvalid follows.
  - After release, a held request is granted again.
- MEM_LAT=1 and MEM_LAT=4 sweeps: rvalid is exactly MEM_LAT cycles after m_en, and busy is high for exactly MEM_LAT cycles.
